bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter LZ_BLANK, default 1, meaning enable leading-zero blanking mask generation.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid_i  input  1  binary value on in_bin_i is offered.
REQ-005 SHALL have port in_bin_i  input  16  unsigned binary value to convert.
REQ-006 SHALL have port in_ready_o  output  1  block can accept a value this cycle.
REQ-007 SHALL have port bcd_o  output  16  four packed BCD digits, digit0 in [3:0] up to digit3 in [15:12]; this is the display-driver hex input.
REQ-008 SHALL have port blank_o  output  4  per-digit blank request, bit i for digit i.
REQ-009 SHALL have port ovf_o  output  1  last accepted value exceeded 9999.
REQ-010 SHALL have port out_valid_o  output  1  one-cycle pulse when bcd_o, blank_o and ovf_o have just been updated.

Function
REQ-011 SHALL implement states IDLE, CONV and DONE.
REQ-012 in_ready_o SHALL be 1 only in IDLE, combinationally from state.
REQ-013 A transfer SHALL occur on a rising edge where in_valid_i and in_ready_o are both 1; in_bin_i SHALL be sampled only then.
REQ-014 On a transfer with in_bin_i <= 9999: shift register loads in_bin_i[13:0], BCD accumulator clears, the 4-bit iteration counter clears, and the state goes IDLE->CONV.
REQ-015 On a transfer with in_bin_i > 9999: the state goes IDLE->DONE with bcd_o=16'hFFFF, blank_o=4'b0000 and ovf_o=1.
REQ-016 Each CONV cycle SHALL do one double-dabble step: add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by 1.
REQ-017 CONV SHALL last exactly 14 cycles, with the counter at 0..13; on the edge ending the step with counter=13, the state goes CONV->DONE.
REQ-018 On entering DONE from CONV, the block SHALL register bcd_o=final accumulator, set ovf_o=0, and register blank_o per REQ-021.
REQ-019 DONE SHALL last exactly 1 cycle with out_valid_o=1, and then go DONE->IDLE unconditionally.
REQ-020 Latency SHALL be: out_valid_o high 14 cycles after the transfer edge for a normal value, 1 cycle for overflow; in_ready_o returns 1 on the following cycle. Throughput is 1 value per 16 cycles normal, 1 per 2 cycles overflow.
REQ-021 With LZ_BLANK=1, blank_o[i] for i=3..1 SHALL be 1 iff digit i and all higher digits are 0. blank_o[0] SHALL always be 0.
REQ-022 With LZ_BLANK=0, blank_o SHALL be constant 4'b0000.
REQ-023 bcd_o, blank_o and ovf_o SHALL hold their values between updates, so a downstream scanner sees stable data during CONV.
REQ-024 in_valid_i during CONV or DONE SHALL be ignored: no sampling, no queuing.
REQ-025 The intermediate accumulator SHALL never be driven onto bcd_o.

Reset
REQ-026 With rst_ni=0, the block SHALL asynchronously force: state=IDLE, bcd_o=16'h0000, ovf_o=0, out_valid_o=0, and counter, shift register and accumulator all 0.
REQ-027 Under reset, blank_o SHALL be 4'b1110 when LZ_BLANK=1 and 4'b0000 when LZ_BLANK=0.
REQ-028 Reset asserted mid-CONV or in DONE SHALL abort the conversion with no out_valid_o pulse.
REQ-029 The block SHALL leave reset synchronously to clk_i, with in_ready_o=1 in the first cycle after deassertion.

Verification
REQ-030 Transfer 0 -> 14 cycles later: out_valid_o=1, bcd_o=16'h0000, blank_o=4'b1110, ovf_o=0.
REQ-031 Transfer 1234 -> out_valid_o exactly 14 cycles after the transfer edge, bcd_o=16'h1234, blank_o=4'b0000; in_ready_o=1 on the next cycle.
REQ-032 Transfer 42 then 9999, with in_valid_i held continuously -> first result 16'h0042 with blank_o=4'b1100, second result 16'h9999; the second transfer happens only when in_ready_o=1; bcd_o stays 16'h0042 between the two results.
REQ-033 Transfer 10000, then 65535 -> each gives out_valid_o 1 cycle after its transfer, bcd_o=16'hFFFF, ovf_o=1; a following transfer of 7 -> bcd_o=16'h0007, ovf_o=0, blank_o=4'b1110.
REQ-034 Pulse rst_ni low 5 cycles into converting 5678 -> outputs return to reset values immediately with no out_valid_o pulse; a new transfer of 5678 then gives bcd_o=16'h5678.
REQ-035 With LZ_BLANK=0, transfer 42 -> bcd_o=16'h0042 and blank_o=4'b0000; exhaustively checking 0..9999 against a reference model gives zero mismatches.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to four-digit BCD converter: one double-dabble step per clock,
// overflow flagging above 9999 and an optional leading-zero blank mask for a display scanner.
module bin2bcd_seq #(
    parameter int LZ_BLANK = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  logic [15:0] in_bin_i,
    output logic        in_ready_o,
    output logic [15:0] bcd_o,
    output logic [3:0]  blank_o,
    output logic        ovf_o,
    output logic        out_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]  BLANK_RST = (LZ_BLANK != 0) ? 4'b1110 : 4'b0000;
    localparam logic [15:0] MAX_DEC   = 16'd9999;

    // state_q is the observable FSM state for checkers bound to this block.
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [13:0] shift_q;
    logic [13:0] shift_d;
    logic [15:0] acc_q;
    logic [15:0] acc_adj;
    logic [15:0] acc_d;
    logic [15:0] bcd_q;
    logic [3:0]  blank_q;
    logic [3:0]  blank_d;
    logic        ovf_q;
    logic        valid_q;

    // Handshake: a value transfers on a rising edge with in_valid_i && in_ready_o;
    // ready is high only in IDLE, and in_valid_i is ignored in every other state.
    assign in_ready_o = (state_q == IDLE);

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d   = {acc_adj[14:0], shift_q[13]};
        shift_d = {shift_q[12:0], 1'b0};
    end

    // Blank a digit only when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        blank_d = 4'b0000;
        if (LZ_BLANK != 0) begin
            blank_d[3] = (acc_d[15:12] == 4'd0);
            blank_d[2] = blank_d[3] && (acc_d[11:8] == 4'd0);
            blank_d[1] = blank_d[2] && (acc_d[7:4] == 4'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 14'd0;
            acc_q   <= 16'd0;
            bcd_q   <= 16'h0000;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (in_bin_i > MAX_DEC) begin
                            bcd_q   <= 16'hFFFF;
                            blank_q <= 4'b0000;
                            ovf_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            shift_q <= in_bin_i[13:0];
                            acc_q   <= 16'd0;
                            cnt_q   <= 4'd0;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 4'd1;
                    // Outputs are only touched with the finished accumulator, never mid-conversion.
                    if (cnt_q == 4'd13) begin
                        bcd_q   <= acc_d;
                        blank_q <= blank_d;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o       = bcd_q;
    assign blank_o     = blank_q;
    assign ovf_o       = ovf_q;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: six instances (lane 0 blanking on, others off) checked every cycle
// against a decimal-arithmetic reference model, plus literal directed checks and a full 0..9999 sweep.
module tb_bin2bcd_seq;

  localparam int NL = 6;
  localparam int SW = 1667;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic main_valid = 1'b0;
  logic [15:0] main_bin = 16'd0;
  logic sweep_on = 1'b0;
  logic chk_en = 1'b0;
  logic [NL-1:0] sw_done;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got %h, expected %h at %0t", name, lane, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [3:0] lz_mask(input int v, input int lz);
    if (lz == 0) return 4'b0000;
    return {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  for (genvar l = 0; l < NL; l++) begin : g_lane
    localparam int LZ = (l == 0) ? 1 : 0;
    localparam int LO = l * SW;
    localparam int HI = ((l + 1) * SW - 1 > 9999) ? 9999 : (l + 1) * SW - 1;

    logic lv, rdy, vo, ov;
    logic [15:0] lb, bcd;
    logic [3:0] blk;
    logic sw_v;
    logic [15:0] sw_b;
    int cur;

    int m_busy, m_val;
    logic m_acc, m_valid, m_ovf;
    logic [15:0] m_bcd;
    logic [3:0] m_blank;

    assign lv = sweep_on ? sw_v : ((l < 2) ? main_valid : 1'b0);
    assign lb = sweep_on ? sw_b : main_bin;
    assign sw_done[l] = sweep_on && (cur > HI) && (m_busy == 0);

    bin2bcd_seq #(.LZ_BLANK(LZ)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(lv), .in_bin_i(lb), .in_ready_o(rdy),
      .bcd_o(bcd), .blank_o(blk), .ovf_o(ov), .out_valid_o(vo)
    );

    // Reference: busy for 15 edges after a normal transfer, result appears after the 14th; 1 edge for overflow.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy = 0; m_val = 0; m_acc = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
        m_bcd = 16'h0000; m_blank = lz_mask(0, LZ);
      end else begin
        m_acc = 1'b0;
        m_valid = 1'b0;
        if (m_busy == 0) begin
          if (lv) begin
            m_acc = 1'b1;
            if (lb > 16'd9999) begin
              m_bcd = 16'hFFFF; m_blank = 4'b0000; m_ovf = 1'b1; m_valid = 1'b1; m_busy = 1;
            end else begin
              m_val = int'(lb); m_busy = 15;
            end
          end
        end else begin
          m_busy--;
          if (m_busy == 1) begin
            m_bcd = to_bcd(m_val); m_blank = lz_mask(m_val, LZ); m_ovf = 1'b0; m_valid = 1'b1;
          end
        end
      end
    end

    always begin
      @(posedge clk);
      #3;
      if (chk_en) begin
        chk("in_ready", l, 32'(rdy), 32'(m_busy == 0));
        chk("out_valid", l, 32'(vo), 32'(m_valid));
        chk("bcd", l, 32'(bcd), 32'(m_bcd));
        chk("blank", l, 32'(blk), 32'(m_blank));
        chk("ovf", l, 32'(ov), 32'(m_ovf));
      end
    end

    always @(negedge clk) begin
      if (!sweep_on) begin
        cur = LO;
        sw_v = 1'b0;
        sw_b = 16'd0;
      end else begin
        if (m_acc) cur = cur + 1;
        if (cur <= HI) begin
          sw_v = 1'b1;
          sw_b = 16'(cur);
        end else begin
          sw_v = 1'b0;
        end
      end
    end
  end

  task automatic wait_vo(output int k);
    k = 0;
    while (!g_lane[0].vo && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_one(input logic [15:0] v, input logic [15:0] e_bcd, input logic [3:0] e_blk,
                         input logic e_ovf, input int e_lat);
    int k;
    @(negedge clk);
    main_valid = 1'b1;
    main_bin = v;
    @(negedge clk);
    main_valid = 1'b0;
    wait_vo(k);
    chk("latency", 0, 32'(k), 32'(e_lat));
    chk("lit_bcd", 0, 32'(g_lane[0].bcd), 32'(e_bcd));
    chk("lit_blank", 0, 32'(g_lane[0].blk), 32'(e_blk));
    chk("lit_blank_nolz", 1, 32'(g_lane[1].blk), 32'(4'b0000));
    chk("lit_bcd_nolz", 1, 32'(g_lane[1].bcd), 32'(e_bcd));
    chk("lit_ovf", 0, 32'(g_lane[0].ov), 32'(e_ovf));
    @(negedge clk);
    chk("ready_after", 0, 32'(g_lane[0].rdy), 32'd1);
    chk("valid_one_cycle", 0, 32'(g_lane[0].vo), 32'd0);
  endtask

  initial begin
    int k;
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("rst_bcd", 0, 32'(g_lane[0].bcd), 32'(16'h0000));
    chk("rst_blank", 0, 32'(g_lane[0].blk), 32'(4'b1110));
    chk("rst_blank_nolz", 1, 32'(g_lane[1].blk), 32'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 0, 32'(g_lane[0].rdy), 32'd1);

    run_one(16'd0, 16'h0000, 4'b1110, 1'b0, 14);
    run_one(16'd1234, 16'h1234, 4'b0000, 1'b0, 14);

    // 42 then 9999 with valid held the whole time.
    @(negedge clk);
    main_valid = 1'b1;
    main_bin = 16'd42;
    @(negedge clk);
    wait_vo(k);
    chk("lz_first_lat", 0, 32'(k), 32'd14);
    chk("lz_first_bcd", 0, 32'(g_lane[0].bcd), 32'(16'h0042));
    chk("lz_first_blank", 0, 32'(g_lane[0].blk), 32'(4'b1100));
    main_bin = 16'd9999;
    @(negedge clk);
    wait_vo(k);
    chk("held_gap", 0, 32'(k + 1), 32'd16);
    chk("held_second_bcd", 0, 32'(g_lane[0].bcd), 32'(16'h9999));
    chk("held_second_blank", 0, 32'(g_lane[0].blk), 32'(4'b0000));
    main_valid = 1'b0;
    repeat (3) @(negedge clk);

    run_one(16'd10000, 16'hFFFF, 4'b0000, 1'b1, 0);
    run_one(16'd65535, 16'hFFFF, 4'b0000, 1'b1, 0);
    run_one(16'd7, 16'h0007, 4'b1110, 1'b0, 14);
    run_one(16'd10, 16'h0010, 4'b1100, 1'b0, 14);
    run_one(16'd100, 16'h0100, 4'b1000, 1'b0, 14);

    // Reset five cycles into a conversion.
    @(negedge clk);
    main_valid = 1'b1;
    main_bin = 16'd5678;
    @(negedge clk);
    main_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 0, 32'(g_lane[0].bcd), 32'(16'h0000));
    chk("abort_blank", 0, 32'(g_lane[0].blk), 32'(4'b1110));
    chk("abort_valid", 0, 32'(g_lane[0].vo), 32'd0);
    chk("abort_ready", 0, 32'(g_lane[0].rdy), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_one(16'd5678, 16'h5678, 4'b0000, 1'b0, 14);
    run_one(16'd42, 16'h0042, 4'b1100, 1'b0, 14);

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      main_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: main_bin = 16'($urandom_range(0, 99));
        1: main_bin = 16'($urandom_range(0, 9999));
        2: main_bin = 16'($urandom_range(10000, 65535));
        default: main_bin = 16'($urandom_range(0, 65535));
      endcase
    end
    @(negedge clk);
    rst_n = 1'b1;
    main_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Exhaustive 0..9999 split across the lanes.
    sweep_on = 1'b1;
    cyc = 0;
    while (sw_done != {NL{1'b1}} && cyc < SW * 16 + 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("sweep_done", 0, 32'(sw_done), 32'({NL{1'b1}}));
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
